// File: rtl/event_fifo_serializer_if.sv
// Bus bundle between the event-row packer (write side), the Q-SPI slave
// (read side) and the event_fifo_serializer buffer. The packer/Q-SPI side
// uses the master modport and the buffer uses the slave modport.
interface event_fifo_serializer_if #(
  parameter int DWIDTH = 136,
  parameter int OWIDTH = 16,
  parameter int DEPTH  = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  // Write side
  logic              wr_en;
  logic [DWIDTH-1:0] wdata;
  logic              full;
  logic              almost_full;
  logic              empty;
  logic [CW-1:0]     numel;

  // Read (serializer) side
  logic              shift_en;
  logic [OWIDTH-1:0] rdata_out;
  logic              out_valid;
  logic              row_start;

  // Error flags
  logic              ovf_sticky;
  logic              udf_sticky;
  logic              clr_flags;

  modport master (
    output wr_en, wdata, shift_en, clr_flags,
    input  full, almost_full, empty, numel,
           rdata_out, out_valid, row_start,
           ovf_sticky, udf_sticky
  );

  modport slave (
    input  wr_en, wdata, shift_en, clr_flags,
    output full, almost_full, empty, numel,
           rdata_out, out_valid, row_start,
           ovf_sticky, udf_sticky
  );
endinterface

// File: rtl/event_fifo_serializer.sv
// Event-row FIFO with a built-in row serializer. Rows of DWIDTH bits are
// stored in a circular buffer; the head row is moved into a holding register
// and presented as NSLICE slices of OWIDTH bits, one slice consumed per
// shift_en. The next row is prefetched on the last slice so a non-empty FIFO
// streams without bubbles. All outputs are decodes of registered state.
module event_fifo_serializer #(
  parameter int DWIDTH    = 136,
  parameter int DEPTH     = 16,
  parameter int OWIDTH    = 16,
  parameter int AFULL_THR = DEPTH - 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  event_fifo_serializer_if.slave      bus
);

  localparam int NSLICE = (DWIDTH + OWIDTH - 1) / OWIDTH;
  localparam int PADW   = NSLICE * OWIDTH;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int PW     = $clog2(DEPTH);
  localparam int SIW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [PW-1:0]  LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [SIW-1:0] LAST_SLICE = SIW'(NSLICE - 1);
  localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0]  AFULL_C    = CW'(AFULL_THR);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;

  ser_state_t        state;
  ser_state_t        next_state;
  logic [SIW-1:0]    slice_idx;
  logic [SIW-1:0]    next_idx;
  logic [DWIDTH-1:0] hold_row;

  logic              full_int;
  logic              empty_int;
  logic              wr_accept;
  logic              pop;
  logic              ovf_event;
  logic              udf_event;
  logic              ovf_q;
  logic              udf_q;

  logic [PADW-1:0]   padded_row;
  logic [SIW-1:0]    slice_sel;
  logic [OWIDTH-1:0] slice_data;

  // Status decodes from the registered count only, so a write and a pop
  // in the same cycle never see each other's effect.
  always_comb begin
    full_int  = (count == DEPTH_C);
    empty_int = (count == '0);
    wr_accept = bus.wr_en && !full_int;
    ovf_event = bus.wr_en && full_int;
    udf_event = bus.shift_en && (state == IDLE);
  end

  // Serializer next-state logic: decide pops, slice advance and idling.
  always_comb begin
    next_state = state;
    next_idx   = slice_idx;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_int) begin
          pop        = 1'b1;
          next_idx   = '0;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (slice_idx != LAST_SLICE) begin
            next_idx = slice_idx + SIW'(1);
          end else if (!empty_int) begin
            pop      = 1'b1;
            next_idx = '0;
          end else begin
            next_idx   = '0;
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_idx   = '0;
      end
    endcase
  end

  // Serializer state, slice index and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      slice_idx <= '0;
      hold_row  <= '0;
    end else begin
      state     <= next_state;
      slice_idx <= next_idx;
      if (pop) begin
        hold_row <= mem[rd_ptr];
      end else if (next_state == IDLE) begin
        hold_row <= '0;
      end
    end
  end

  // Row storage; contents need no reset because pointers and count gate access.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.wdata;
    end
  end

  // Pointers wrap explicitly at DEPTH-1 so any DEPTH works; count tracks
  // accepted writes minus pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q && !bus.clr_flags) || ovf_event;
      udf_q <= (udf_q && !bus.clr_flags) || udf_event;
    end
  end

  // Slice selection: the row is zero-extended to NSLICE*OWIDTH and slice 0
  // comes from the top or the bottom depending on MSB_FIRST.
  always_comb begin
    padded_row = PADW'(hold_row);
    slice_sel  = MSB_FIRST ? (LAST_SLICE - slice_idx) : slice_idx;
    slice_data = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (slice_sel == SIW'(k)) begin
        slice_data = padded_row[k*OWIDTH +: OWIDTH];
      end
    end
  end

  // Output decodes of registered state.
  always_comb begin
    bus.full        = full_int;
    bus.almost_full = (count >= AFULL_C);
    bus.empty       = empty_int;
    bus.numel       = count;
    bus.out_valid   = (state == SHIFT);
    bus.row_start   = (state == SHIFT) && (slice_idx == '0);
    bus.rdata_out   = (state == SHIFT) ? slice_data : '0;
    bus.ovf_sticky  = ovf_q;
    bus.udf_sticky  = udf_q;
  end

endmodule

// File: doc/event_fifo_serializer.md
# event_fifo_serializer

Second-generation OpenDVS readout buffer: a synchronous FIFO of DWIDTH-bit event rows with a built-in row serializer that presents each row to the Q-SPI side as OWIDTH-bit slices. One slice is consumed per `shift_en` pulse. Additions:
- configurable slice width and slice order
- zero-bubble row prefetch
- almost-full threshold
- sticky overflow/underflow flags
- a count output wide enough to represent a full FIFO

The block sits between the event-row packer (write side) and the Q-SPI slave (read side), all on one clock.

## Interface
- DWIDTH, 136, event row width in bits (≥1)
- DEPTH, 16, FIFO entries (≥2, any integer, not only powers of two)
- OWIDTH, 16, slice width presented to Q-SPI (1..DWIDTH)
- AFULL_THR, DEPTH-4, `almost_full` asserted when stored count ≥ AFULL_THR (1..DEPTH)
- MSB_FIRST, 1, 1: slice 0 carries the most-significant bits; 0: slice 0 carries bits [OWIDTH-1:0]
- Derived: NSLICE = ceil(DWIDTH/OWIDTH); CW = $clog2(DEPTH+1)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wr_en  in  1  write request for `wdata`
- wdata  in  DWIDTH  row to store
- full  out  1  stored count == DEPTH
- almost_full  out  1  stored count ≥ AFULL_THR
- empty  out  1  stored count == 0; excludes the row in the holding register
- numel  out  CW  stored entries, 0..DEPTH; excludes the holding register
- shift_en  in  1  consume current slice
- rdata_out  out  OWIDTH  current slice
- out_valid  out  1  holding register contains a row
- row_start  out  1  `out_valid` and slice index == 0
- ovf_sticky  out  1  a write was dropped
- udf_sticky  out  1  `shift_en` was asserted while `out_valid`=0
- clr_flags  in  1  synchronous clear of both sticky flags

## Operation
- **Storage:** circular buffer with read pointer, write pointer and count. Pointers wrap from DEPTH-1 to 0 explicitly; they do not rely on power-of-two overflow.
- **Write:** accepted iff `wr_en` && !`full`, where `full` is based on the registered count. A write while `full` is dropped, even if a pop occurs in the same cycle, and sets `ovf_sticky`.
- **Row layout:** each row is zero-extended at the MSB end to NSLICE*OWIDTH bits.
  - MSB_FIRST=1: slice k = bits [(NSLICE-k)*OWIDTH-1 -: OWIDTH].
  - MSB_FIRST=0: slice k = bits [k*OWIDTH +: OWIDTH].
  - Padding bits read as 0.
- **Serializer FSM:**
  - IDLE: `out_valid`=0, `rdata_out`=0.
    - If `empty`=0, pop the head into the holding register, set slice index to 0 and go to SHIFT.
  - SHIFT: `out_valid`=1, `rdata_out` = slice[index].
    - On `shift_en` with index < NSLICE-1: index+1.
    - On `shift_en` with index == NSLICE-1 and `empty`=0: pop the next row in the same cycle, index=0, stay in SHIFT. No bubble.
    - On `shift_en` with index == NSLICE-1 and `empty`=1: go to IDLE.
- **Pop decision:** uses the registered `empty`. A row written in cycle N is never popped in cycle N.
- **Count update:** `numel` += write accepted − pop. Simultaneous write and pop leaves the count unchanged.
- **Underflow:** `shift_en` in IDLE is ignored and sets `udf_sticky`.
- **Flag priority:** if `clr_flags` coincides with a new overflow/underflow event, the flag ends set (set wins).
- **Reset:** pointers, count, slice index, FSM=IDLE, holding register, and both sticky flags are cleared.
- **Reset values:** `empty`=1, `full`=0, `almost_full`=0 (`almost_full`=1 if AFULL_THR==0, which is disallowed), `numel`=0, `out_valid`=0, `row_start`=0, `rdata_out`=0, `ovf_sticky`=0, `udf_sticky`=0.
- **Reset mid-row:** the partial row and all stored rows are discarded. No slice is emitted after reset deasserts until a new write occurs.

## Timing
- All outputs are registered state or pure decodes of registered state. There is no combinational path from inputs to outputs.
- **Write to first slice:** `wr_en` at edge N into an idle, empty block gives `numel`=1 and `empty`=0 after N. The pop happens at N+1, and `out_valid`=1 with slice 0 after N+1. Latency is 2 cycles.
- **Slice advance:** `shift_en` sampled at edge M; the new slice is visible after M.
- **Continuous streaming:** a full row takes exactly NSLICE `shift_en` cycles. Back-to-back rows stream at one slice per cycle with a non-empty FIFO.
- **Flag timing:** `full`, `almost_full`, `empty` and `numel` reflect the count after the edge that changed it. The sticky flags set on the edge after the offending event.

## Test plan
- **Reset and single row:** reset, then write row 136'h AB_0102…0F10 (MSB byte AB) once, with DWIDTH=136, OWIDTH=16, MSB_FIRST=1.
  - `out_valid` rises 2 cycles after the write.
  - Slice 0 = 16'h00AB, followed by 8 slices in order.
  - `row_start` is high only on slice 0.
  - After the 9th `shift_en`, `out_valid`=0 and `empty`=1.
- **Fill to full:** 17 consecutive writes with no `shift_en`.
  - Pop 1 moves into the holding register, so `numel` reaches 16 and `full`=1 after write 17.
  - `almost_full` rises when `numel`=12.
  - `ovf_sticky`=0.
  - An 18th write is dropped: `ovf_sticky`=1 and `numel` stays 16.
- **Back-to-back streaming:** 3 rows stored, then `shift_en` held high for 27 cycles.
  - `out_valid` is continuously 1.
  - `row_start` pulses at cycles 0, 9 and 18.
  - Idle afterwards.
- **Simultaneous write and pop:** with `numel`=5, apply `wr_en` in the same cycle as the last-slice `shift_en`.
  - `numel` stays 5.
  - The next row appears with no bubble.
- **Underflow and clear:**
  - `shift_en` while IDLE gives `udf_sticky`=1 and outputs unchanged.
  - `clr_flags` clears it, but if the same cycle also has `shift_en` while IDLE, `udf_sticky` stays 1.
- **Order and reset mid-row:**
  - With MSB_FIRST=0 and DWIDTH=20, OWIDTH=8: row 20'hABCDE yields 8'hDE, 8'hBC, 8'h0A.
  - Asserting `rst_n`=0 after the 2nd slice gives all outputs at reset values, and no slice until a new write.
